// File: rtl/seq_div24.sv
// seq_div24: multi-cycle restoring divider, 2*WIDTH-bit dividend over a
// WIDTH-bit divisor, one quotient bit per clock, MSB first.
//
// Ports:
//   clk       in   system clock, rising-edge
//   rst       in   synchronous active-high reset
//   startDiv  in   start request, sampled only while idle
//   Dividend  in   [2*WIDTH-1:0] unsigned numerator
//   Divisor   in   [WIDTH-1:0]   unsigned denominator
//   Quotient  out  [WIDTH-1:0]   registered quotient
//   Remainder out  [WIDTH-1:0]   registered remainder
//   doneDiv   out  one-cycle result-valid pulse
//   divOvf    out  overflow / divide-by-zero flag, valid with doneDiv
//
// Optional feature macro: SEQ_DIV_OVF_CHECK_EN
//   defined   -> overflow inputs are detected at start and finish in 1 cycle
//   undefined -> divOvf is tied to 0 and every division takes WIDTH cycles
module seq_div24 #(
   parameter int WIDTH = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               startDiv,
   input  logic [2*WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0]   Divisor,
   output logic [WIDTH-1:0]   Quotient,
   output logic [WIDTH-1:0]   Remainder,
   output logic               doneDiv,
   output logic               divOvf
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH-1:0] r_quo;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_q_out;
   logic [WIDTH-1:0] r_r_out;

   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_sub;
   logic             w_ge;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;
   logic             w_last;
   logic             w_ovf;

   // The partial remainder stays below the divisor between steps, so WIDTH
   // bits hold it; only the shifted trial value needs the extra bit.
   assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
   assign w_sub     = w_shift - {1'b0, r_dvs};
   assign w_ge      = (w_shift >= {1'b0, r_dvs});
   assign w_rem_nxt = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
   assign w_last    = (r_cnt == CW'(WIDTH - 1));

`ifdef SEQ_DIV_OVF_CHECK_EN
   // Quotient cannot fit in WIDTH bits when the upper dividend half
   // already reaches the divisor; zero divisor is caught by the same test.
   assign w_ovf = (Divisor == '0) ||
                  (Dividend[2*WIDTH-1:WIDTH] >= Divisor);
`else
   assign w_ovf = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (startDiv) w_next = w_ovf ? DONE : CALC;
         CALC:    if (w_last)   w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem   <= '0;
         r_dvd   <= '0;
         r_dvs   <= '0;
         r_quo   <= '0;
         r_cnt   <= '0;
         r_q_out <= '0;
         r_r_out <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (startDiv) begin
                  r_rem <= Dividend[2*WIDTH-1:WIDTH];
                  r_dvd <= Dividend[WIDTH-1:0];
                  r_dvs <= Divisor;
                  r_quo <= '0;
                  r_cnt <= '0;
                  if (w_ovf) begin
                     r_q_out <= '1;
                     r_r_out <= '0;
                  end
               end
            end
            CALC: begin
               r_rem <= w_rem_nxt;
               r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
               r_quo <= w_quo_nxt;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  r_q_out <= w_quo_nxt;
                  r_r_out <= w_rem_nxt;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SEQ_DIV_OVF_CHECK_EN
   logic r_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (r_state == IDLE && startDiv) begin
         if (w_ovf) r_ovf <= 1'b1;
      end else if (r_state == CALC && w_last) begin
         r_ovf <= 1'b0;
      end
   end

   assign divOvf = r_ovf;
`else
   assign divOvf = 1'b0;
`endif

   assign Quotient  = r_q_out;
   assign Remainder = r_r_out;
   assign doneDiv   = (r_state == DONE);

endmodule

// File: tb/tb_seq_div24.sv
// tb_seq_div24: directed self-checking bench for seq_div24.
// Table of hand-computed divisions plus reset/abort/hold-start sequences.
module tb_seq_div24;

   localparam int W = 24;

   logic           clk;
   logic           rst;
   logic           startDiv;
   logic [2*W-1:0] Dividend;
   logic [W-1:0]   Divisor;
   logic [W-1:0]   Quotient;
   logic [W-1:0]   Remainder;
   logic           doneDiv;
   logic           divOvf;

   int n_pass;
   int n_tot;

   seq_div24 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .startDiv  (startDiv),
      .Dividend  (Dividend),
      .Divisor   (Divisor),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .doneDiv   (doneDiv),
      .divOvf    (divOvf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2*W-1:0] dvd;
      logic [W-1:0]   dvs;
      logic [W-1:0]   q;
      logic [W-1:0]   r;
      logic           ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Edges counted after the start edge until doneDiv is seen; 200 = timeout.
   task automatic wait_done(output int n);
      n = 0;
      while (n < 200) begin
         @(posedge clk);
         #1;
         n++;
         if (doneDiv) return;
      end
   endtask

   task automatic start_op(input logic [2*W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      Dividend = a;
      Divisor  = b;
      startDiv = 1'b1;
      @(posedge clk);
      #1;
      startDiv = 1'b0;
   endtask

   task automatic no_done_for(input string name, input int cycles);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (doneDiv) seen++;
      end
      chk(name, seen, 0);
   endtask

   initial begin
      int n;
      n_pass   = 0;
      n_tot    = 0;
      rst      = 1'b1;
      startDiv = 1'b0;
      Dividend = '0;
      Divisor  = '0;

      vecs.push_back('{48'd2363,           24'd17,       24'd139,      24'd0,   1'b0});
      vecs.push_back('{48'd65720,          24'd124,      24'd530,      24'd0,   1'b0});
      vecs.push_back('{48'd1000,           24'd7,        24'd142,      24'd6,   1'b0});
      vecs.push_back('{48'hFFFFFE000001,   24'hFFFFFF,   24'hFFFFFF,   24'd0,   1'b0});
      vecs.push_back('{48'd1234567,        24'd1000,     24'd1234,     24'd567, 1'b0});
      vecs.push_back('{48'd5,              24'd9,        24'd0,        24'd5,   1'b0});
      vecs.push_back('{48'd0,              24'd5,        24'd0,        24'd0,   1'b0});
      vecs.push_back('{48'h00000F000000,   24'd16,       24'hF00000,   24'd0,   1'b0});
`ifdef SEQ_DIV_OVF_CHECK_EN
      vecs.push_back('{48'd1234,           24'd0,        24'hFFFFFF,   24'd0,   1'b1});
      vecs.push_back('{48'h000011000000,   24'h000011,   24'hFFFFFF,   24'd0,   1'b1});
      vecs.push_back('{48'd100,            24'd1,        24'd100,      24'd0,   1'b0});
`endif

      repeat (2) @(posedge clk);
      #1;
      chk("rst_q",    Quotient,  0);
      chk("rst_r",    Remainder, 0);
      chk("rst_done", doneDiv,   0);
      chk("rst_ovf",  divOvf,    0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         start_op(vecs[i].dvd, vecs[i].dvs);
         wait_done(n);
         chk($sformatf("v%0d_lat", i), n, vecs[i].ovf ? 1 : W);
         chk($sformatf("v%0d_q", i),   Quotient,  vecs[i].q);
         chk($sformatf("v%0d_r", i),   Remainder, vecs[i].r);
         chk($sformatf("v%0d_ovf", i), divOvf,    vecs[i].ovf);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_pulse", i), doneDiv, 0);
         chk($sformatf("v%0d_hold", i),  Quotient, vecs[i].q);
      end

      // Reset in the middle of CALC aborts without a done pulse.
      start_op(48'd2363, 24'd17);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_q", Quotient,  0);
      chk("abort_r", Remainder, 0);
      no_done_for("abort_nodone", W + 4);
      chk("abort_q2", Quotient, 0);

      start_op(48'd2363, 24'd17);
      wait_done(n);
      chk("fresh_lat", n, W);
      chk("fresh_q",   Quotient,  139);
      chk("fresh_r",   Remainder, 0);

      // Reset and start on the same edge: start is dropped.
      @(negedge clk);
      rst      = 1'b1;
      startDiv = 1'b1;
      Dividend = 48'd1000;
      Divisor  = 24'd7;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      startDiv = 1'b0;
      no_done_for("rststart_nodone", W + 4);
      chk("rststart_q", Quotient, 0);

      // Operands change and start stays high during CALC; the held start
      // is then taken again from IDLE with the new operands.
      @(negedge clk);
      Dividend = 48'd1000;
      Divisor  = 24'd7;
      startDiv = 1'b1;
      @(posedge clk);
      #1;
      Dividend = 48'd65720;
      Divisor  = 24'd124;
      wait_done(n);
      chk("hold_lat1", n, W);
      chk("hold_q1",   Quotient,  142);
      chk("hold_r1",   Remainder, 6);
      @(posedge clk);
      #1;
      chk("hold_idle", doneDiv, 0);
      @(posedge clk);
      #1;
      startDiv = 1'b0;
      wait_done(n);
      chk("hold_lat2", n, W);
      chk("hold_q2",   Quotient,  530);
      chk("hold_r2",   Remainder, 0);
      no_done_for("hold_single", 6);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
